fpu_addsub_param: RTL and testbench
===================================

// Module: fpu_addsub_param
// PURPOSE
// - Parametrised IEEE 754 binary add/subtract unit; next generation of the single-precision FPU adder.
// - Configurable exponent/mantissa widths and a per-operation add/sub select.
// - Full subnormal handling, guard/round/sticky rounding and exception flags.
// - 3-stage pipeline with valid/ready backpressure; sits between the FPU operand issue logic and the result writeback arbiter.
// PARAMETERS
// - EXP_W   8   exponent field width (>=3)
// - MAN_W   23  stored mantissa width, excluding the hidden bit (>=2)
// - W       derived localparam = 1+EXP_W+MAN_W; not overridable
// PORTS
// - clk        in   1   clock, all logic on posedge
// - rst        in   1   synchronous reset, active-high
// - in_valid   in   1   operands present
// - in_ready   out  1   stage 1 can accept; transfer when in_valid&&in_ready
// - op_sub     in   1   1: a-b (b sign inverted at stage 1); 0: a+b
// - a          in   W   operand A {sign,exp,man}
// - b          in   W   operand B
// - out_valid  out  1   result/flags valid
// - out_ready  in   1   consumer accepts; transfer when out_valid&&out_ready
// - result     out  W   packed result
// - flags      out  3   {nv invalid, of overflow, nx inexact}
// BEHAVIOUR
// - Reset: out_valid=0, result=0, flags=0, all stage-valid bits 0; in_ready=1 the cycle after rst falls.
// - Pipeline:
//   - S1: unpack, classify, swap so |X|>=|Y|, compute exponent difference.
//   - S2: align with sticky collect, add/sub on MAN_W+4 bits (hidden+man+G+R+S).
//   - S3: leading-zero normalise, round, pack, flags.
// - Latency: exactly 3 cycles from accept to out_valid when unstalled; throughput 1/cycle.
// - Backpressure: stage k advances when its output register is empty or downstream accepts.
//   - in_ready = !(S1 full && S1 stalled), combinational from stage state and out_ready.
//   - No bubbles are inserted. Results leave strictly in acceptance order. Nothing is dropped or duplicated.
//   - result/flags stay stable while out_valid && !out_ready.
// - Subnormals: exp field 0 -> hidden bit 0, effective exponent 1.
//   - Results below normal range pack as subnormal (exp field 0); no flush.
// - Specials, in priority order:
//   - Any NaN input -> canonical qNaN {0,all-1 exp,1,0...}; nv=1 only if an input is signalling (man MSB 0).
//   - +inf + -inf, after op_sub inversion -> qNaN, nv=1.
//   - Single inf -> that inf, signed.
// - Zero results:
//   - Exact zero from unlike signs -> +0.
//   - (-0)+(-0) -> -0.
// - Overflow: rounded exponent reaches all-ones -> +/-inf, of=1, nx=1.
// - nx=1 whenever any discarded G/R/S bit is nonzero.
// - Reset mid-operation: all in-flight operations are discarded; no output for them after rst.
// - Simultaneous accept and emit in the same cycle is legal and is required at full throughput.
// CONFIGURATION
// - Macro FPU_ADDSUB_RNE_EN.
// - Defined: round-to-nearest, ties-to-even, using G/R/S.
//   - A mantissa carry-out from rounding increments the exponent.
// - Undefined: round-toward-zero (truncate G/R/S); nx still reported.
//   - Overflow yields the max finite value, not inf; of=1, nx=1.
// TESTING
// - 3F800000 + 3F800000, op_sub=0 -> 40000000, flags=000, out_valid exactly 3 cycles after accept.
// - 3F800000 - 3F800000, op_sub=1 -> 00000000 (+0); 80000000 + 80000000 -> 80000000.
// - 7F800000 + FF800000 -> 7FC00000, nv=1; 7F800001 + 3F800000 -> 7FC00000, nv=1; 7FC00000 + 0 -> 7FC00000, nv=0.
// - 7F7FFFFF + 7F7FFFFF: with RNE -> 7F800000, flags=011; without RNE -> 7F7FFFFF, flags=011.
// - 3F800001 + 33800000 (tie):
//   - RNE -> 3F800002, nx=1; 3F800000 + 33800000 -> 3F800000, nx=1.
//   - Truncate -> 3F800001, nx=1.
// - Subnormal: 00000001 + 00000001 -> 00000002, flags=000.
// - Backpressure: issue 6 back-to-back ops with out_ready=0 for 8 cycles.
//   - in_ready drops after 3 accepts; the 3 held results are emitted in order.
//   - No loss after out_ready=1; assert rst mid-stream -> out_valid=0 the next cycle.

Source files
------------

// File: rtl/fpu_addsub_param.sv
// Parametrised IEEE 754 binary add/subtract with a 3-stage valid/ready pipeline.
// Macro FPU_ADDSUB_RNE_EN selects round-to-nearest-even; otherwise round-toward-zero.
module fpu_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op_sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [2:0]   flags
);

    localparam int AW = MAN_W + 4;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [MAN_W-1:0] MAN_ZERO = {MAN_W{1'b0}};
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [31:0]      AW32     = 32'(AW);
    localparam logic [31:0]      EXP_MAX32 = 32'(EXP_ONES);

    function automatic logic [31:0] lzc(input logic [AW-1:0] v);
        logic [31:0] n;
        logic        done;
        n    = 32'd0;
        done = 1'b0;
        for (int i = AW - 1; i >= 0; i--) begin
            if (!done && !v[i]) begin
                n = n + 32'd1;
            end else begin
                done = 1'b1;
            end
        end
        return n;
    endfunction

    // handshake state
    logic v1_r, v2_r, v3_r;
    logic s1_load_s, s2_load_s, s3_load_s;

    // stage 1 signals and registers
    logic             sa_s, sb_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_snan_s, b_snan_s, swap_s;
    logic [EXP_W-1:0] ea_s, eb_s, ex_s, ey_s, diff_s;
    logic [MAN_W-1:0] ma_s, mb_s;
    logic [MAN_W:0]   mx_s, my_s;
    logic             sx_s, sy_s, spec_s, spec_nv_s;
    logic [W-1:0]     spec_val_s;
    logic             s1_sx_r, s1_sy_r, s1_spec_r, s1_spec_nv_r;
    logic [EXP_W-1:0] s1_ex_r, s1_diff_r;
    logic [MAN_W:0]   s1_mx_r, s1_my_r;
    logic [W-1:0]     s1_spec_val_r;

    // stage 2 signals and registers
    logic [31:0]      diff32_s, sh_s;
    logic [2*AW-1:0]  wide_s;
    logic [AW-1:0]    ay_s, xe_s;
    logic [AW:0]      sum_s;
    logic             s2_sx_r, s2_sy_r, s2_spec_r, s2_spec_nv_r;
    logic [EXP_W-1:0] s2_ex_r;
    logic [AW:0]      s2_sum_r;
    logic [W-1:0]     s2_spec_val_r;

    // stage 3 signals and output registers
    logic [31:0]      exp32_s, lz_s, shl_s, exp_n_s, exp_f_s;
    logic [AW-1:0]    norm_s;
    logic             g_s, r_s, st_s, nx_s, inc_s;
    logic [MAN_W+1:0] mant_rnd_s;
    logic [MAN_W-1:0] man_o_s;
    logic [W-1:0]     res_s, res_r;
    logic [2:0]       flags_s, flags_r;

    assign s3_load_s = !v3_r || out_ready;
    assign s2_load_s = !v2_r || s3_load_s;
    assign s1_load_s = !v1_r || s2_load_s;
    assign in_ready  = s1_load_s;
    assign out_valid = v3_r;
    assign result    = res_r;
    assign flags     = flags_r;

    // Stage 1: unpack, classify specials, order operands so |X| >= |Y|
    always_comb begin
        sa_s     = a[W-1];
        sb_s     = b[W-1] ^ op_sub;
        ea_s     = a[W-2:MAN_W];
        eb_s     = b[W-2:MAN_W];
        ma_s     = a[MAN_W-1:0];
        mb_s     = b[MAN_W-1:0];
        a_nan_s  = (ea_s == EXP_ONES) && (ma_s != MAN_ZERO);
        b_nan_s  = (eb_s == EXP_ONES) && (mb_s != MAN_ZERO);
        a_inf_s  = (ea_s == EXP_ONES) && (ma_s == MAN_ZERO);
        b_inf_s  = (eb_s == EXP_ONES) && (mb_s == MAN_ZERO);
        a_snan_s = a_nan_s && !ma_s[MAN_W-1];
        b_snan_s = b_nan_s && !mb_s[MAN_W-1];
        swap_s   = b[W-2:0] > a[W-2:0];
        if (swap_s) begin
            sx_s = sb_s;
            sy_s = sa_s;
            ex_s = (eb_s == EXP_ZERO) ? EXP_ONE : eb_s;
            ey_s = (ea_s == EXP_ZERO) ? EXP_ONE : ea_s;
            mx_s = {eb_s != EXP_ZERO, mb_s};
            my_s = {ea_s != EXP_ZERO, ma_s};
        end else begin
            sx_s = sa_s;
            sy_s = sb_s;
            ex_s = (ea_s == EXP_ZERO) ? EXP_ONE : ea_s;
            ey_s = (eb_s == EXP_ZERO) ? EXP_ONE : eb_s;
            mx_s = {ea_s != EXP_ZERO, ma_s};
            my_s = {eb_s != EXP_ZERO, mb_s};
        end
        diff_s     = ex_s - ey_s;
        spec_s     = 1'b0;
        spec_nv_s  = 1'b0;
        spec_val_s = {W{1'b0}};
        if (a_nan_s || b_nan_s) begin
            spec_s     = 1'b1;
            spec_val_s = QNAN;
            spec_nv_s  = a_snan_s || b_snan_s;
        end else if (a_inf_s && b_inf_s && (sa_s != sb_s)) begin
            spec_s     = 1'b1;
            spec_val_s = QNAN;
            spec_nv_s  = 1'b1;
        end else if (a_inf_s) begin
            spec_s     = 1'b1;
            spec_val_s = {sa_s, EXP_ONES, MAN_ZERO};
        end else if (b_inf_s) begin
            spec_s     = 1'b1;
            spec_val_s = {sb_s, EXP_ONES, MAN_ZERO};
        end else begin
            spec_s = 1'b0;
        end
    end

    // Stage 2: align Y with sticky collection, then add or subtract magnitudes
    always_comb begin
        diff32_s = 32'(s1_diff_r);
        sh_s     = (diff32_s > AW32) ? AW32 : diff32_s;
        wide_s   = {s1_my_r, 3'b000, {AW{1'b0}}} >> sh_s;
        ay_s     = {wide_s[2*AW-1:AW+1], wide_s[AW] | (|wide_s[AW-1:0])};
        xe_s     = {s1_mx_r, 3'b000};
        if (s1_sx_r != s1_sy_r) begin
            sum_s = {1'b0, xe_s} - {1'b0, ay_s};
        end else begin
            sum_s = {1'b0, xe_s} + {1'b0, ay_s};
        end
    end

    // Stage 3: normalise (never below effective exponent 1), round, pack, flags
    always_comb begin
        exp32_s = 32'(s2_ex_r);
        lz_s    = lzc(s2_sum_r[AW-1:0]);
        if (s2_sum_r[AW]) begin
            norm_s  = {s2_sum_r[AW:2], s2_sum_r[1] | s2_sum_r[0]};
            shl_s   = 32'd0;
            exp_n_s = exp32_s + 32'd1;
        end else begin
            if (lz_s < exp32_s) begin
                shl_s = lz_s;
            end else begin
                shl_s = exp32_s - 32'd1;
            end
            norm_s  = s2_sum_r[AW-1:0] << shl_s;
            exp_n_s = exp32_s - shl_s;
        end
        g_s  = norm_s[2];
        r_s  = norm_s[1];
        st_s = norm_s[0];
        nx_s = g_s | r_s | st_s;
`ifdef FPU_ADDSUB_RNE_EN
        inc_s = g_s & (r_s | st_s | norm_s[3]);
`else
        inc_s = 1'b0;
`endif
        mant_rnd_s = {1'b0, norm_s[AW-1:3]} + {{(MAN_W+1){1'b0}}, inc_s};
        // a subnormal that rounds up into the hidden bit becomes the smallest normal
        if (mant_rnd_s[MAN_W+1]) begin
            man_o_s = mant_rnd_s[MAN_W:1];
            exp_f_s = exp_n_s + 32'd1;
        end else if (mant_rnd_s[MAN_W]) begin
            man_o_s = mant_rnd_s[MAN_W-1:0];
            exp_f_s = exp_n_s;
        end else begin
            man_o_s = mant_rnd_s[MAN_W-1:0];
            exp_f_s = 32'd0;
        end
        res_s   = {W{1'b0}};
        flags_s = 3'b000;
        if (s2_spec_r) begin
            res_s   = s2_spec_val_r;
            flags_s = {s2_spec_nv_r, 2'b00};
        end else if (s2_sum_r == {(AW+1){1'b0}}) begin
            res_s   = {s2_sx_r & s2_sy_r, {(W-1){1'b0}}};
            flags_s = 3'b000;
        end else if (exp_f_s >= EXP_MAX32) begin
`ifdef FPU_ADDSUB_RNE_EN
            res_s   = {s2_sx_r, EXP_ONES, MAN_ZERO};
`else
            res_s   = {s2_sx_r, EXP_ONES - EXP_ONE, {MAN_W{1'b1}}};
`endif
            flags_s = 3'b011;
        end else begin
            res_s   = {s2_sx_r, exp_f_s[EXP_W-1:0], man_o_s};
            flags_s = {2'b00, nx_s};
        end
    end

    // Stage valid bits and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r    <= 1'b0;
            v2_r    <= 1'b0;
            v3_r    <= 1'b0;
            res_r   <= {W{1'b0}};
            flags_r <= 3'b000;
        end else begin
            if (s1_load_s) v1_r <= in_valid;
            if (s2_load_s) v2_r <= v1_r;
            if (s3_load_s) v3_r <= v2_r;
            if (s3_load_s && v2_r) begin
                res_r   <= res_s;
                flags_r <= flags_s;
            end
        end
    end

    // Datapath stage registers, loaded only with valid data
    always_ff @(posedge clk) begin
        if (s1_load_s && in_valid) begin
            s1_sx_r       <= sx_s;
            s1_sy_r       <= sy_s;
            s1_ex_r       <= ex_s;
            s1_diff_r     <= diff_s;
            s1_mx_r       <= mx_s;
            s1_my_r       <= my_s;
            s1_spec_r     <= spec_s;
            s1_spec_nv_r  <= spec_nv_s;
            s1_spec_val_r <= spec_val_s;
        end
        if (s2_load_s && v1_r) begin
            s2_sx_r       <= s1_sx_r;
            s2_sy_r       <= s1_sy_r;
            s2_ex_r       <= s1_ex_r;
            s2_sum_r      <= sum_s;
            s2_spec_r     <= s1_spec_r;
            s2_spec_nv_r  <= s1_spec_nv_r;
            s2_spec_val_r <= s1_spec_val_r;
        end
    end

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Directed scoreboard bench for fpu_addsub_param (single precision); expectations follow FPU_ADDSUB_RNE_EN.
module tb_fpu_addsub_param;

    logic        clk, rst, in_valid, in_ready, op_sub, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [2:0]  flags;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

`ifdef FPU_ADDSUB_RNE_EN
    localparam logic [31:0] OVF_RES = 32'h7F800000;
    localparam logic [31:0] TIE_RES = 32'h3F800002;
`else
    localparam logic [31:0] OVF_RES = 32'h7F7FFFFF;
    localparam logic [31:0] TIE_RES = 32'h3F800001;
`endif

    fpu_addsub_param dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic sample_out();
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed output %h expected no output", result);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, "_res"}, result, e.res);
                chk({e.tag, "_flags"}, 32'(flags), 32'(e.flg));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample_out();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sub, input logic [31:0] er, input logic [2:0] ef);
        bit acc;
        int n;
        a = av; b = bv; op_sub = sub; in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            sample_out();
            acc = in_ready;
            if (acc) sb.push_back('{er, ef, tag});
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL %s_accept: observed in_ready 0 expected accept within 50 cycles", tag);
        end
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain: observed %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        int          lat;
        bit          seen;
        logic [31:0] hold_res;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_sub = 1'b0; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;

        // latency of a single operation
        send("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        in_valid = 1'b0;
        lat = 1;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        chk("latency", 32'(lat), 32'd3);
        sample_out();
        @(posedge clk);
        #1;

        // directed operations, back to back
        send("sub_zero",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        send("neg_zeros",  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        send("inf_m_inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
        send("snan",       32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        send("qnan",       32'h7FC00000, 32'h00000000, 1'b0, 32'h7FC00000, 3'b000);
        send("inf_sub",    32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        send("neg_inf",    32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);
        send("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, OVF_RES,      3'b011);
        send("tie_odd",    32'h3F800001, 32'h33800000, 1'b0, TIE_RES,      3'b001);
        send("tie_even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        send("subnorm",    32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000);
        send("cancel_sub", 32'h00800000, 32'h007FFFFF, 1'b1, 32'h00000001, 3'b000);
        send("three_m1",   32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
        send("neg_half",   32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 3'b000);
        drain();

        // backpressure: consumer stalls while six ops are offered
        out_ready = 1'b0;
        send("bp1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        send("bp2", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000);
        send("bp3", 32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 3'b000);
        a = 32'h40000000; b = 32'h40000000; op_sub = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'h0);
        chk("bp_out_valid", 32'(out_valid), 32'h1);
        hold_res = 32'h40000000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("bp_hold_res", result, hold_res);
            chk("bp_hold_in_ready", 32'(in_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send("bp4", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000);
        send("bp5", 32'h40800000, 32'h3F800000, 1'b0, 32'h40A00000, 3'b000);
        send("bp6", 32'h40400000, 32'h40400000, 1'b0, 32'h40C00000, 3'b000);
        drain();

        // reset with operations in flight discards them
        send("rst_a", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        send("rst_b", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000);
        rst = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        repeat (5) tick();
        chk("rst_mid_no_output", 32'(out_valid), 32'h0);

        send("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
